// File: rtl/vd1_pkg.sv
// Shared definitions for the vd1_scan mux scanner: FSM states, select codes, channel count.
package vd1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int NCH = 5;

  localparam logic [2:0] CH_U = 3'b000;
  localparam logic [2:0] CH_V = 3'b001;
  localparam logic [2:0] CH_W = 3'b010;
  localparam logic [2:0] CH_X = 3'b011;
  localparam logic [2:0] CH_Y = 3'b100;

  // Codes that alias onto y at the downstream mux (1xx decodes as y)
  localparam logic [2:0] AL_A = 3'b101;
  localparam logic [2:0] AL_B = 3'b110;
  localparam logic [2:0] AL_C = 3'b111;

endpackage

// File: rtl/vd1_settle_timer.sv
// 4-bit loadable down-counter that paces how long each select code is held.
module vd1_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero,
  output logic       one
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);
  assign one  = (cnt == 4'd1);

endmodule

// File: rtl/vd1_scan.sv
// Scans a 5-to-1 mux by stepping its select code and sampling m into a 5-bit word.
// Optional macro VD1_SCAN_ALIAS_CHECK_EN adds codes 101..111 and checks they read back as y.
import vd1_pkg::*;

module vd1_scan #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       s2,
  output logic       s1,
  output logic       s0,
  input  logic       m,
  output logic       busy,
  output logic       done,
  output logic [4:0] word,
  output logic       alias_err
);

  localparam logic [3:0] SETTLE_V   = 4'(SETTLE);
  localparam bit         SKIP_DRIVE = (SETTLE == 0);

  state_t           state, state_nxt;
  logic [2:0]       code, code_nxt;
  logic [NCH-1:0]   collect, collect_nxt;
  logic [NCH-1:0]   word_r;
  logic             word_ld;
  logic             tmr_load, tmr_dec, tmr_zero, tmr_one;

`ifdef VD1_SCAN_ALIAS_CHECK_EN
  localparam logic [2:0] LAST_CODE = AL_C;
  logic alias_r;

  // Sticky: any alias-code sample that disagrees with the captured y bit
  always_ff @(posedge clk) begin
    if (rst) begin
      alias_r <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      alias_r <= 1'b0;
    end else if (state == ST_CAPTURE &&
                 (code == AL_A || code == AL_B || code == AL_C) &&
                 m != collect[4]) begin
      alias_r <= 1'b1;
    end
  end

  assign alias_err = alias_r;
`else
  localparam logic [2:0] LAST_CODE = CH_Y;
  assign alias_err = 1'b0;
`endif

  vd1_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (SETTLE_V),
    .dec      (tmr_dec),
    .zero     (tmr_zero),
    .one      (tmr_one)
  );

  always_comb begin
    state_nxt   = state;
    code_nxt    = code;
    collect_nxt = collect;
    word_ld     = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    case (state)
      ST_IDLE: begin
        code_nxt = CH_U;
        if (start) begin
          collect_nxt = '0;
          tmr_load    = 1'b1;
          state_nxt   = SKIP_DRIVE ? ST_CAPTURE : ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        tmr_dec = 1'b1;
        if (tmr_zero || tmr_one) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        case (code)
          CH_U:    collect_nxt[0] = m;
          CH_V:    collect_nxt[1] = m;
          CH_W:    collect_nxt[2] = m;
          CH_X:    collect_nxt[3] = m;
          CH_Y:    collect_nxt[4] = m;
          default: ;
        endcase
        if (code == LAST_CODE) begin
          // word picks up the final sample on the same edge that enters DONE
          word_ld   = 1'b1;
          code_nxt  = CH_U;
          state_nxt = ST_DONE;
        end else begin
          code_nxt  = code + 3'd1;
          tmr_load  = 1'b1;
          state_nxt = SKIP_DRIVE ? ST_CAPTURE : ST_DRIVE;
        end
      end
      ST_DONE: begin
        code_nxt  = CH_U;
        state_nxt = ST_IDLE;
      end
      default: begin
        code_nxt  = CH_U;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      code    <= CH_U;
      collect <= '0;
      word_r  <= '0;
    end else begin
      state   <= state_nxt;
      code    <= code_nxt;
      collect <= collect_nxt;
      if (word_ld) word_r <= collect_nxt;
    end
  end

  assign s2   = code[2];
  assign s1   = code[1];
  assign s0   = code[0];
  assign busy = (state == ST_DRIVE) || (state == ST_CAPTURE);
  assign done = (state == ST_DONE);
  assign word = word_r;

endmodule

// File: tb/tb_vd1_scan.sv
// Randomized bench for vd1_scan: three instances (SETTLE 0, 1, 3) driven by a behavioural mux model.
module tb_vd1_scan;

  localparam int NI = 3;
`ifdef VD1_SCAN_ALIAS_CHECK_EN
  localparam int NCODES = 8;
`else
  localparam int NCODES = 5;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start[NI];
  logic       s2[NI], s1[NI], s0[NI];
  logic       m[NI];
  logic       busy[NI], done[NI], alias_err[NI];
  logic [4:0] word[NI];

  logic [4:0] chan[NI];
  logic       fen[NI];
  logic [2:0] fcode[NI];
  logic       fval[NI];

  int settle_of[NI] = '{0, 1, 3};
  int n_chk = 0;
  int n_err = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    vd1_scan #(.SETTLE((g == 0) ? 0 : ((g == 1) ? 1 : 3))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start[g]),
      .s2        (s2[g]),
      .s1        (s1[g]),
      .s0        (s0[g]),
      .m         (m[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .word      (word[g]),
      .alias_err (alias_err[g])
    );
  end

  // External 5-to-1 mux: 1xx selects y; one code may be forced to a fixed value
  function automatic logic mux_out(input logic [4:0] ch, input logic [2:0] c,
                                   input logic fe, input logic [2:0] fc, input logic fv);
    if (fe && c == fc) return fv;
    if (c[2]) return ch[4];
    return ch[c[1:0]];
  endfunction

  always_comb begin
    for (int i = 0; i < NI; i++)
      m[i] = mux_out(chan[i], {s2[i], s1[i], s0[i]}, fen[i], fcode[i], fval[i]);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic run_scan(input int d, input logic [4:0] ch, input logic fe,
                          input logic [2:0] fc, input logic fv, input bit noise);
    int         per, total;
    logic [4:0] exp_w;
    logic       exp_a;
    logic [2:0] c;
    per   = settle_of[d] + 1;
    total = NCODES * per;
    chan[d] = ch; fen[d] = fe; fcode[d] = fc; fval[d] = fv;
    for (int i = 0; i < 5; i++) begin
      c = 3'(i);
      exp_w[i] = mux_out(ch, c, fe, fc, fv);
    end
    exp_a = 1'b0;
    for (int i = 5; i < NCODES; i++) begin
      c = 3'(i);
      if (mux_out(ch, c, fe, fc, fv) != exp_w[4]) exp_a = 1'b1;
    end

    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    for (int k = 1; k <= total; k++) begin
      check("sel", {29'd0, s2[d], s1[d], s0[d]}, 32'((k - 1) / per));
      check("busy_scan", 32'(busy[d]), 32'd1);
      check("done_early", 32'(done[d]), 32'd0);
      start[d] = (noise && k == 3) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
    end
    start[d] = 1'b0;
    check("done_pulse", 32'(done[d]), 32'd1);
    check("busy_done", 32'(busy[d]), 32'd0);
    check("word", 32'(word[d]), 32'(exp_w));
    check("alias_err", 32'(alias_err[d]), 32'(exp_a));
    if (noise) start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    check("done_clear", 32'(done[d]), 32'd0);
    check("busy_idle", 32'(busy[d]), 32'd0);
    check("sel_idle", {29'd0, s2[d], s1[d], s0[d]}, 32'd0);
    check("word_hold", 32'(word[d]), 32'(exp_w));
    if (noise) begin
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        check("no_requeue_busy", 32'(busy[d]), 32'd0);
        check("no_requeue_done", 32'(done[d]), 32'd0);
      end
    end
  endtask

  task automatic rst_mid_scan(input int d, input logic [4:0] ch);
    chan[d] = ch; fen[d] = 1'b0; fcode[d] = 3'd0; fval[d] = 1'b0;
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
    end
    check("busy_before_rst", 32'(busy[d]), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_sel", {29'd0, s2[d], s1[d], s0[d]}, 32'd0);
    check("rst_busy", 32'(busy[d]), 32'd0);
    check("rst_word", 32'(word[d]), 32'd0);
    check("rst_done", 32'(done[d]), 32'd0);
    check("rst_alias", 32'(alias_err[d]), 32'd0);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      check("rst_no_done", 32'(done[d]), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0; chan[i] = '0; fen[i] = 1'b0; fcode[i] = '0; fval[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check("reset_sel", {29'd0, s2[i], s1[i], s0[i]}, 32'd0);
      check("reset_busy", 32'(busy[i]), 32'd0);
      check("reset_done", 32'(done[i]), 32'd0);
      check("reset_word", 32'(word[i]), 32'd0);
      check("reset_alias", 32'(alias_err[i]), 32'd0);
    end
    rst = 1'b0;

    run_scan(1, 5'b01101, 1'b0, 3'd0, 1'b0, 1'b0);
    run_scan(0, 5'b10010, 1'b0, 3'd0, 1'b0, 1'b0);
    run_scan(1, 5'b10110, 1'b0, 3'd0, 1'b0, 1'b1);
    run_scan(1, 5'b10000, 1'b1, 3'b110, 1'b0, 1'b0);
    run_scan(1, 5'b10101, 1'b0, 3'd0, 1'b0, 1'b0);
    run_scan(2, 5'b11011, 1'b0, 3'd0, 1'b0, 1'b1);

    for (int n = 0; n < 18; n++)
      run_scan(int'($urandom_range(0, NI - 1)), 5'($urandom), 1'($urandom),
               3'($urandom), 1'($urandom), 1'($urandom));

    rst_mid_scan(1, 5'b11111);

    // rst and start together in IDLE: rst must win
    start[0] = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    rst = 1'b0;
    check("rst_over_start", 32'(busy[0]), 32'd0);
    @(posedge clk); #1;
    check("rst_over_start_idle", 32'(busy[0]), 32'd0);

    run_scan(0, 5'b00111, 1'b0, 3'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
